mux7seg_capture: RTL

Receiving end of the multiplexed 4-digit 7-segment display bus driven by the anode scanner. Samples the active-low anode strobes and active-low segment lines, waits for each strobe window to settle, decodes the segment pattern back to a hex nibble, and stores it in the matching digit slot. Used for display loop-back checking on the board, and as a monitor that recovers a 16-bit value from any scanned display source.

---
 rtl/mux7seg_if.sv | 32 +++
 rtl/mux7seg_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mux7seg_if.sv
// Display-bus bundle between a 4-digit anode scanner (master) and the capture monitor (slave).
// The decimal-point signals exist only when MUX7SEG_DP_EN is defined.
interface mux7seg_if;
   logic [3:0]  an;
   logic [6:0]  seg;
`ifdef MUX7SEG_DP_EN
   logic        dp;
   logic [3:0]  dp_q;
`endif
   logic [15:0] dat;
   logic [3:0]  valid;
   logic        frame_done;
   logic        err;

   modport master (
`ifdef MUX7SEG_DP_EN
      output dp,
      input  dp_q,
`endif
      output an, seg,
      input  dat, valid, frame_done, err
   );

   modport slave (
`ifdef MUX7SEG_DP_EN
      input  dp,
      output dp_q,
`endif
      input  an, seg,
      output dat, valid, frame_done, err
   );
endinterface

// File: rtl/mux7seg_capture.sv
// Recovers hex digits from a scanned active-low 7-seg bus (optional decimal point: MUX7SEG_DP_EN).
// Capture lands SETTLE+2 cycles after a stable input change; no backpressure, pure monitor.
module mux7seg_capture #(
   parameter int SETTLE = 4
) (
   input  logic     clk,
   input  logic     rst,
   mux7seg_if.slave bus
);
   typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);
`ifdef MUX7SEG_DP_EN
   localparam int SW = 12;
`else
   localparam int SW = 11;
`endif

   logic [SW-1:0] smp_w, s1_q, s2_q;
   logic [3:0]    s_an;
   logic [6:0]    s_seg;
   logic          chg;
   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [3:0]    mask_q, mask_d;
   logic [15:0]   dat_q, dat_d;
   logic [3:0]    valid_q, valid_d;
   logic          fd_q, fd_d;
   logic          err_q, err_d;
   logic          eval;
   logic          an_blank, an_bad;
   logic [1:0]    slot;
   logic [4:0]    dec;
`ifdef MUX7SEG_DP_EN
   logic [3:0]    dpl_q, dpl_d;

   assign smp_w    = {bus.dp, bus.an, bus.seg};
   assign bus.dp_q = dpl_q;
`else
   assign smp_w    = {bus.an, bus.seg};
`endif

   // Returns {decodable, nibble}
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h40: decode = 5'h10;
         7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;
         7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;
         7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;
         7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;
         7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;
         7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;
         7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;
         7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   assign s_an  = s2_q[10:7];
   assign s_seg = s2_q[6:0];
   // s1 is the sample about to enter s2: a difference means the next synchronized sample changes
   assign chg   = (s1_q != s2_q);
   assign dec   = decode(s_seg);

   always_comb begin
      an_blank = 1'b0;
      an_bad   = 1'b0;
      slot     = 2'd0;
      case (s_an)
         4'b1110: slot = 2'd0;
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         4'b1111: an_blank = 1'b1;
         default: an_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      eval    = 1'b0;
      case (state_q)
         ST_WAIT, ST_HOLD: begin
            if (chg) begin
               state_d = ST_SETTLE;
               cnt_d   = 8'd1;
            end
         end
         ST_SETTLE: begin
            if (chg) begin
               cnt_d = 8'd1;
            end else if (cnt_q == SETTLE_C) begin
               eval    = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      fd_d    = (mask_q == 4'hF);
      // a full mask clears first, so a capture on the same edge lands in the fresh mask
      mask_d  = fd_d ? 4'h0 : mask_q;
      dat_d   = dat_q;
      valid_d = valid_q;
      err_d   = 1'b0;
`ifdef MUX7SEG_DP_EN
      dpl_d   = dpl_q;
`endif
      if (eval) begin
         if (an_bad) begin
            err_d = 1'b1;
         end else if (!an_blank) begin
            if (dec[4]) begin
               dat_d[{slot, 2'b00} +: 4] = dec[3:0];
               valid_d[slot]             = 1'b1;
               mask_d[slot]              = 1'b1;
`ifdef MUX7SEG_DP_EN
               dpl_d[slot]               = ~s2_q[11];
`endif
            end else begin
               err_d         = 1'b1;
               valid_d[slot] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '1;
         s2_q    <= '1;
         state_q <= ST_WAIT;
         cnt_q   <= 8'd0;
         mask_q  <= 4'h0;
         dat_q   <= 16'h0000;
         valid_q <= 4'h0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef MUX7SEG_DP_EN
         dpl_q   <= 4'h0;
`endif
      end else begin
         s1_q    <= smp_w;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dat_q   <= dat_d;
         valid_q <= valid_d;
         fd_q    <= fd_d;
         err_q   <= err_d;
`ifdef MUX7SEG_DP_EN
         dpl_q   <= dpl_d;
`endif
      end
   end

   assign bus.dat        = dat_q;
   assign bus.valid      = valid_q;
   assign bus.frame_done = fd_q;
   assign bus.err        = err_q;
endmodule
